// File: rtl/booth_r4_mult_if.sv
// Operand/result bundle for booth_r4_mult: request side drives operands and start,
// multiplier side returns status and the held product.
interface booth_r4_mult_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               mode_signed;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, mode_signed, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, mode_signed, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_r4_mult.sv
// Radix-4 Booth multiplier, signed or unsigned, one operand pair per start pulse.
// Operands are extended by two bits so one extra digit makes unsigned MSB=1 exact.
module booth_r4_mult #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  booth_r4_mult_if.slave bus
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int QW = WIDTH + 2;
  localparam int AW = WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               last_digit;
  logic [QW-1:0]      m_ext;
  logic [QW-1:0]      q_cap;
  logic [QW-1:0]      q_sr;
  logic               q_m1;
  logic [AW-1:0]      acc;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] product_q;

  logic [AW-1:0]      m_sx;
  logic [AW-1:0]      m_x2;
  logic [AW-1:0]      addend;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_nxt;
  logic [QW-1:0]      q_nxt;
  logic               m_ext_bit;
  logic               q_ext_bit;

  assign last_digit = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          accept    = 1'b1;
        end
      end
      LOAD:    state_nxt = ITER;
      ITER:    if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m_ext_bit = bus.mode_signed & bus.multiplicand[WIDTH-1];
  assign q_ext_bit = bus.mode_signed & bus.multiplier[WIDTH-1];

  // Digit recoding from {Q1,Q0,Q-1}; negative multiples via two's complement.
  always_comb begin
    m_sx = {m_ext[QW-1], m_ext};
    m_x2 = {m_ext, 1'b0};
    case ({q_sr[1:0], q_m1})
      3'b001, 3'b010: addend = m_sx;
      3'b011:         addend = m_x2;
      3'b100:         addend = ~m_x2 + AW'(1);
      3'b101, 3'b110: addend = ~m_sx + AW'(1);
      default:        addend = '0;
    endcase
    sum     = acc + addend;
    acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt   = {sum[1:0], q_sr[QW-1:2]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ext     <= '0;
      q_cap     <= '0;
      q_sr      <= '0;
      q_m1      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      if (accept) begin
        m_ext <= {{2{m_ext_bit}}, bus.multiplicand};
        q_cap <= {{2{q_ext_bit}}, bus.multiplier};
      end
      case (state)
        LOAD: begin
          acc  <= '0;
          q_m1 <= 1'b0;
          q_sr <= q_cap;
          cnt  <= '0;
        end
        ITER: begin
          acc  <= acc_nxt;
          q_sr <= q_nxt;
          q_m1 <= q_sr[1];
          cnt  <= cnt + CW'(1);
          // Low 2*WIDTH bits of the shifted {acc,Q} chain after the final digit.
          if (last_digit) product_q <= {acc_nxt[WIDTH-3:0], q_nxt};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == LOAD) || (state == ITER);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;

endmodule

// File: doc/booth_r4_mult.md
# booth_r4_mult

Parametrised radix-4 Booth multiplier with its datapath and sequencing FSM combined in one block. It accepts one operand pair per start pulse, in signed or unsigned mode, and returns the full 2·WIDTH-bit product after a fixed latency. A single-cycle done pulse marks the result, and the product is held until the next result. It replaces the radix-2 start/load/compare/add-sub/shift controller-plus-datapath pairing: it retires two multiplier bits per cycle and adds an unsigned mode.

## Interface
- WIDTH, 8, operand width in bits. Must be even and ≥4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- mode_signed  in  1  1 = two's-complement operands, 0 = unsigned. Captured with the operands.
- multiplicand  in  WIDTH  operand M. Captured when start is accepted.
- multiplier  in  WIDTH  operand Q. Captured when start is accepted.
- busy  out  1  high in LOAD and ITER.
- done  out  1  one-cycle pulse, high in the DONE state.
- product  out  2·WIDTH  result register.

## Operation
- States:
  - IDLE: wait for start.
  - LOAD: initialise.
  - ITER: one radix-4 digit per cycle.
  - DONE: result pulse.
- Transitions:
  - IDLE→LOAD when start=1 at a clock edge. That edge captures M, Q and mode into internal registers.
  - LOAD→ITER unconditionally.
  - ITER→ITER until the digit counter reaches N−1, then ITER→DONE.
  - DONE→IDLE unconditionally.
  - Unused state encodings → IDLE.
- N = WIDTH/2 + 1 digits.
- Operand extension: M and Q are extended to WIDTH+2 bits. Sign extension is used when mode_signed=1, zero extension when 0. The extra digit makes unsigned operands with MSB=1 correct.
- LOAD: clears the accumulator (WIDTH+3 bits) and the Q−1 bit, and loads the extended Q into the shift register. The digit counter is reset to 0.
- ITER recoding: the digit is taken from {Q[1],Q[0],Q−1}.
  - 000, 111 → 0
  - 001, 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101, 110 → −M
- ITER update, in the same cycle: add the selected multiple (WIDTH+3-bit sign-extended, subtraction by two's complement) to the accumulator. Then arithmetic-shift the {accumulator, Q, Q−1} chain right by 2.
- DONE entry: product is loaded with the low 2·WIDTH bits of {accumulator, Q}. The result is exact in both modes; there is no overflow case.
- product changes only on the edge entering DONE. It holds through IDLE and through the next computation, until the next DONE.
- start is ignored in LOAD, ITER and DONE, and is not queued. Operand and mode input changes after the accept edge have no effect.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, busy=0, done=0, product=0.
  - Internal registers and counter cleared.
- Reset asserted mid-computation aborts the operation. No done pulse follows.
- Latency: with the accept edge at t0, LOAD is the cycle after t0, ITER occupies the next N cycles, and done is high during cycle N+2. That is WIDTH/2+3 cycles; WIDTH=8 → done in the 7th cycle.
- busy rises in the cycle after the accept edge and falls when DONE is entered.
- done is high for exactly one cycle. product is valid in that cycle and thereafter.
- Back-to-back: the earliest next accept is the edge ending the first IDLE cycle after DONE. Peak throughput is one result per N+3 cycles.
- start held high continuously restarts on every return to IDLE.

## Test plan
- WIDTH=8, unsigned, 255×255 → done in the 7th cycle after accept, product=0xFE01. Also 0×200 → 0x0000.
- WIDTH=8, signed:
  - −128×−128 → 0x4000
  - −1×127 → 0xFF81
  - 127×−128 → 0xC080
  - Same bit patterns with unsigned mode: 0x80×0x80 → 0x4000, 0xFF×0x7F → 0x7E81.
- Start at each of the LOAD, ITER and DONE states with new operands → ignored. The first product is unchanged and exactly one done pulse occurs per accepted start.
- Assert reset for 1 cycle during the 3rd ITER cycle → busy, done and product go to 0 asynchronously, with no done pulse. A fresh 3×5 afterwards → 0x000F.
- start held high for 3 operations in a row (6×7, −2×−3, 9×−1 signed) → products 0x002A, 0x0006, 0xFFF7. done pulses are spaced N+3=8 cycles apart, and product is stable between pulses.
- WIDTH=16 and WIDTH=4: 1000 random operand pairs in each mode against a reference model → all match. Latency is N+2 (11 and 5 cycles respectively).
